// File: rtl/game_controller_pkg.sv
// Shared state codes, command bundle and command decode for the memory-game controller.
// Latency/backpressure: none, definitions only.
package game_controller_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] S_INIT       = 3'd0;
    localparam logic [STATE_W-1:0] S_SETUP      = 3'd1;
    localparam logic [STATE_W-1:0] S_PLAY_FPGA  = 3'd2;
    localparam logic [STATE_W-1:0] S_PLAY_USER  = 3'd3;
    localparam logic [STATE_W-1:0] S_CHECK      = 3'd4;
    localparam logic [STATE_W-1:0] S_NEXT_ROUND = 3'd5;
    localparam logic [STATE_W-1:0] S_RESULT     = 3'd6;

    typedef enum logic [STATE_W-1:0] {
        ST_INIT       = S_INIT,
        ST_SETUP      = S_SETUP,
        ST_PLAY_FPGA  = S_PLAY_FPGA,
        ST_PLAY_USER  = S_PLAY_USER,
        ST_CHECK      = S_CHECK,
        ST_NEXT_ROUND = S_NEXT_ROUND,
        ST_RESULT     = S_RESULT
    } state_e;

    typedef struct packed {
        logic r1;
        logic r2;
        logic e1;
        logic e2;
        logic e3;
        logic e4;
        logic sel;
    } cmd_t;

    localparam cmd_t CMD_RESET = '{r1: 1'b1, r2: 1'b1, default: 1'b0};

    // Datapath commands asserted while the FSM sits in a given state.
    function automatic cmd_t decode_cmd(input state_e s);
        cmd_t c;
        c = '0;
        case (s)
            ST_INIT:       begin c.r1 = 1'b1; c.r2 = 1'b1; end
            ST_SETUP:      c.e1 = 1'b1;
            ST_PLAY_FPGA:  begin c.e3 = 1'b1; c.r2 = 1'b1; end
            ST_PLAY_USER:  c.e2 = 1'b1;
            ST_NEXT_ROUND: c.e4 = 1'b1;
            ST_RESULT:     c.sel = 1'b1;
            default:       c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronises and debounces the active-low ENTER key; one-cycle pulse on an accepted press.
// Latency: 2 sync flops + DEBOUNCE_CYCLES + 1 pulse register; no backpressure (pulse is fire-and-forget).
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press_p
);

    localparam int unsigned          CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta_q, meta_d;
    logic             sync_q, sync_d;
    logic             level_q, level_d;
    logic             pulse_q, pulse_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        meta_d  = key_n;
        sync_d  = meta_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        pulse_d = 1'b0;
        if (sync_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            // Level has differed for DEBOUNCE_CYCLES consecutive cycles.
            cnt_d   = '0;
            level_d = sync_q;
            pulse_d = ~sync_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q  <= 1'b1;
            sync_q  <= 1'b1;
            level_q <= 1'b1;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            meta_q  <= meta_d;
            sync_q  <= sync_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press_p = pulse_q;

endmodule

// File: rtl/game_controller.sv
// Memory-game control FSM driving Datapath commands; outputs registered from next state (same cycle as state_o).
// No backpressure; ENTER debounced internally. CTRL_AUTO_RESTART_EN adds a timed RESULT -> INIT exit.
module game_controller
    import game_controller_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned RESTART_CYCLES  = 250_000_000
) (
    input  logic               CLOCK_50,
    input  logic               RESET_N,
    input  logic               KEY_ENTER,
    input  logic               end_FPGA,
    input  logic               end_User,
    input  logic               end_time,
    input  logic               match,
    output logic               R1,
    output logic               R2,
    output logic               E1,
    output logic               E2,
    output logic               E3,
    output logic               E4,
    output logic               SEL,
    output logic [STATE_W-1:0] state_o
);

    state_e state_q, state_d;
    cmd_t   cmd_q, cmd_d;
    logic   enter_p;
    logic   dwell_done;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .clk    (CLOCK_50),
        .rst_n  (RESET_N),
        .key_n  (KEY_ENTER),
        .press_p(enter_p)
    );

`ifdef CTRL_AUTO_RESTART_EN
    localparam int unsigned          DWELL_W    = $clog2(RESTART_CYCLES + 1);
    localparam logic [DWELL_W-1:0]   DWELL_LAST = DWELL_W'(RESTART_CYCLES - 1);

    logic [DWELL_W-1:0] dwell_q, dwell_d;

    // Held at zero outside RESULT, so each RESULT visit starts a fresh dwell.
    always_comb begin
        dwell_d = '0;
        if (state_q == ST_RESULT) begin
            dwell_d = dwell_q + 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            dwell_q <= '0;
        end else begin
            dwell_q <= dwell_d;
        end
    end

    assign dwell_done = (state_q == ST_RESULT) && (dwell_q == DWELL_LAST);
`else
    logic unused_cfg;
    assign unused_cfg = (RESTART_CYCLES != 0);
    assign dwell_done = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:       state_d = ST_SETUP;
            ST_SETUP:      if (enter_p) state_d = ST_PLAY_FPGA;
            ST_PLAY_FPGA:  if (end_FPGA) state_d = ST_PLAY_USER;
            ST_PLAY_USER: begin
                // Timeout has priority over a simultaneous press.
                if (end_time) begin
                    state_d = ST_RESULT;
                end else if (enter_p) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (!match || end_User) begin
                    state_d = ST_RESULT;
                end else begin
                    state_d = ST_NEXT_ROUND;
                end
            end
            ST_NEXT_ROUND: state_d = ST_PLAY_FPGA;
            ST_RESULT:     if (enter_p || dwell_done) state_d = ST_INIT;
            default:       state_d = ST_INIT;
        endcase
        cmd_d = decode_cmd(state_d);
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_INIT;
            cmd_q   <= CMD_RESET;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
        end
    end

    assign R1      = cmd_q.r1;
    assign R2      = cmd_q.r2;
    assign E1      = cmd_q.e1;
    assign E2      = cmd_q.e2;
    assign E3      = cmd_q.e3;
    assign E4      = cmd_q.e4;
    assign SEL     = cmd_q.sel;
    assign state_o = state_q;

endmodule

// File: tb/tb_game_controller.sv
// Directed vector bench for game_controller with DEBOUNCE_CYCLES=4, RESTART_CYCLES=10.
module tb_game_controller;

    logic       CLOCK_50;
    logic       RESET_N;
    logic       KEY_ENTER;
    logic       end_FPGA, end_User, end_time, match;
    logic       R1, R2, E1, E2, E3, E4, SEL;
    logic [2:0] state_o;
    logic [6:0] cmds;

    assign cmds = {R1, R2, E1, E2, E3, E4, SEL};

    // Expected command vectors, bit order {R1,R2,E1,E2,E3,E4,SEL}
    localparam logic [6:0] O_INIT  = 7'b1100000;
    localparam logic [6:0] O_SETUP = 7'b0010000;
    localparam logic [6:0] O_FPGA  = 7'b0100100;
    localparam logic [6:0] O_USER  = 7'b0001000;
    localparam logic [6:0] O_CHECK = 7'b0000000;
    localparam logic [6:0] O_NEXT  = 7'b0000010;
    localparam logic [6:0] O_RES   = 7'b0000001;

    game_controller #(
        .DEBOUNCE_CYCLES(4),
        .RESTART_CYCLES (10)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .KEY_ENTER(KEY_ENTER),
        .end_FPGA (end_FPGA),
        .end_User (end_User),
        .end_time (end_time),
        .match    (match),
        .R1       (R1),
        .R2       (R2),
        .E1       (E1),
        .E2       (E2),
        .E3       (E3),
        .E4       (E4),
        .SEL      (SEL),
        .state_o  (state_o)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        bit         key;
        bit         efpga;
        bit         euser;
        bit         etime;
        bit         mt;
        int         cyc;
        logic [2:0] st;
        logic [6:0] outs;
    } vec_t;

    vec_t vecs[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic void add(input bit key, input bit efpga, input bit euser, input bit etime,
                                input bit mt, input int cyc, input logic [2:0] st, input logic [6:0] outs);
        vec_t v;
        v.key = key; v.efpga = efpga; v.euser = euser; v.etime = etime; v.mt = mt;
        v.cyc = cyc; v.st = st; v.outs = outs;
        vecs.push_back(v);
    endfunction

    task automatic check(input string nm, input logic [2:0] exp_st, input logic [6:0] exp_o);
        n_chk++;
        if (state_o === exp_st && cmds === exp_o) begin
            n_pass++;
        end else begin
            $display("FAIL %s: state_o=%0d cmds=%b, expected state_o=%0d cmds=%b",
                     nm, state_o, cmds, exp_st, exp_o);
        end
    endtask

    // Each vector: drive at a falling edge, let cyc rising edges pass, sample at a falling edge.
    task automatic run(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            KEY_ENTER = vecs[i].key;
            end_FPGA  = vecs[i].efpga;
            end_User  = vecs[i].euser;
            end_time  = vecs[i].etime;
            match     = vecs[i].mt;
            repeat (vecs[i].cyc) @(negedge CLOCK_50);
            check($sformatf("vec%0d", i), vecs[i].st, vecs[i].outs);
        end
    endtask

    // Called one falling edge after RESULT was entered; leaves the DUT in SETUP with the key released.
    task automatic leave_result(input string tag);
        KEY_ENTER = 1'b1;
        end_FPGA = 1'b0; end_User = 1'b0; end_time = 1'b0; match = 1'b0;
`ifdef CTRL_AUTO_RESTART_EN
        repeat (9) @(negedge CLOCK_50);
        check({tag, "_dwell"}, 3'd6, O_RES);
        @(negedge CLOCK_50);
        check({tag, "_auto_init"}, 3'd0, O_INIT);
        @(negedge CLOCK_50);
        check({tag, "_setup"}, 3'd1, O_SETUP);
`else
        for (int c = 0; c < 100; c++) begin
            @(negedge CLOCK_50);
            check({tag, "_hold"}, 3'd6, O_RES);
        end
        KEY_ENTER = 1'b0;
        repeat (7) @(negedge CLOCK_50);
        check({tag, "_press_init"}, 3'd0, O_INIT);
        @(negedge CLOCK_50);
        check({tag, "_setup"}, 3'd1, O_SETUP);
        KEY_ENTER = 1'b1;
        repeat (8) @(negedge CLOCK_50);
`endif
    endtask

    int p1, p2, p3, p4;

    initial begin
        RESET_N = 1'b1;
        KEY_ENTER = 1'b1;
        end_FPGA = 1'b0; end_User = 1'b0; end_time = 1'b0; match = 1'b0;

        // Part 1: bounce rejection, press timing, win round, final round to RESULT
        add(1,0,0,0,0, 1, 3'd1, O_SETUP);
        add(0,0,0,0,0, 3, 3'd1, O_SETUP);
        add(1,0,0,0,0, 8, 3'd1, O_SETUP);
        add(0,0,0,0,0, 6, 3'd1, O_SETUP);
        add(0,0,0,0,0, 1, 3'd2, O_FPGA);
        add(0,0,0,0,0, 1, 3'd2, O_FPGA);
        add(1,0,0,0,0, 8, 3'd2, O_FPGA);
        add(1,1,0,0,0, 1, 3'd3, O_USER);
        add(0,0,0,0,1, 6, 3'd3, O_USER);
        add(0,0,0,0,1, 1, 3'd4, O_CHECK);
        add(0,0,0,0,1, 1, 3'd5, O_NEXT);
        add(0,0,0,0,1, 1, 3'd2, O_FPGA);
        add(1,0,0,0,1, 8, 3'd2, O_FPGA);
        add(1,1,0,0,0, 1, 3'd3, O_USER);
        add(0,0,1,0,1, 7, 3'd4, O_CHECK);
        add(0,0,1,0,1, 1, 3'd6, O_RES);
        p1 = vecs.size();
        // Part 2: end_time coincides with the press pulse
        add(0,0,0,0,0, 7, 3'd2, O_FPGA);
        add(1,0,0,0,0, 8, 3'd2, O_FPGA);
        add(1,1,0,0,0, 1, 3'd3, O_USER);
        add(0,0,0,0,0, 6, 3'd3, O_USER);
        add(0,0,0,1,0, 1, 3'd6, O_RES);
        p2 = vecs.size();
        // Part 3: wrong entry
        add(0,0,0,0,0, 7, 3'd2, O_FPGA);
        add(1,0,0,0,0, 8, 3'd2, O_FPGA);
        add(1,1,0,0,0, 1, 3'd3, O_USER);
        add(0,0,0,0,0, 7, 3'd4, O_CHECK);
        add(0,0,0,0,0, 1, 3'd6, O_RES);
        p3 = vecs.size();
        // Part 4: reach PLAY_USER for the mid-game reset
        add(0,0,0,0,0, 7, 3'd2, O_FPGA);
        add(1,0,0,0,0, 8, 3'd2, O_FPGA);
        add(1,1,0,0,0, 1, 3'd3, O_USER);
        p4 = vecs.size();

        #1 RESET_N = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        check("reset", 3'd0, O_INIT);
        RESET_N = 1'b1;

        run(0, p1);
        leave_result("win");
        run(p1, p2);
        leave_result("timeout");
        run(p2, p3);
        leave_result("lose");
        run(p3, p4);

        // Short reset pulse well between clock edges
        #2 RESET_N = 1'b0;
        #1 RESET_N = 1'b1;
        #1 check("async_reset", 3'd0, O_INIT);
        @(negedge CLOCK_50);
        check("post_reset_setup", 3'd1, O_SETUP);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
